// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the execute stage and the
// multi-cycle multiply/divide sequencer.
//
// Handshake: the requester raises start with op/a/b stable and holds them
// until it samples ready=1 at a rising edge; that edge accepts the operation.
// start while ready=0 is ignored. flush aborts whatever is in flight and wins
// over a start presented in the same cycle. done (with bad_op for illegal ops)
// is a one-cycle pulse in the cycle after hi/lo are written.
//
// Signals:
//   start, op[2:0], a[31:0], b[31:0], flush   requester -> sequencer
//   ready, busy, done, hi[31:0], lo[31:0],
//   div_by_zero, bad_op                      sequencer -> requester
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  logic        bad_op;

  modport master (
    output start, op, a, b, flush,
    input  ready, busy, done, hi, lo, div_by_zero, bad_op
  );

  modport slave (
    input  start, op, a, b, flush,
    output ready, busy, done, hi, lo, div_by_zero, bad_op
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer owning the HI/LO pair.
//
// Accepts one op at a time (MULTU/MULT/DIVU/DIV/MTHI/MTLO). Multiplies write
// HI/LO MUL_LATENCY edges after acceptance; divides run a radix-2 restoring
// divider for 32 steps plus one sign-fix step. Divide-by-zero finishes one
// edge after acceptance with lo=all-ones, hi=dividend.
//
// Optional feature: define MULDIV_DIV_EN to build the divider. Without it,
// DIV/DIVU are reported as illegal ops and div_by_zero is tied low.
//
// Parameters:
//   MUL_LATENCY  edges from acceptance to HI/LO write for MULT/MULTU (1..8)
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   bus        muldiv_seq_if.slave (start/op/a/b/flush in; ready/busy/done/
//              hi/lo/div_by_zero/bad_op out)
//   dbg_state  current FSM state (IDLE=0, MUL=1, DIV=2, FIX=3, DZ=4)
module muldiv_seq #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  muldiv_seq_if.slave bus,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DZ   = 3'd4
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        bad_q;

  // Multiplier operands are held for the whole latency window; the product
  // is taken from the held copies on the write edge.
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  // Low 64 bits of the product of sign-extended operands equal the signed
  // product, so one unsigned multiplier serves MULT and MULTU.
  always_comb begin
    ext_a   = {{32{mul_sign & mul_a[31]}}, mul_a};
    ext_b   = {{32{mul_sign & mul_b[31]}}, mul_b};
    product = ext_a * ext_b;
  end

  wire accept = bus.start & !bus.flush;

`ifdef MULDIV_DIV_EN
  // quo starts as the dividend magnitude and shifts quotient bits in from
  // the right while dividend bits leave from the left. In DZ it holds the
  // raw dividend for the hi write.
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic        dz_q;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] trial;

  always_comb begin
    a_neg = bus.op[0] & bus.a[31];
    b_neg = bus.op[0] & bus.b[31];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    // Borrow out of bit 33 means the shifted remainder is below the divisor.
    trial = {rem, quo[31]} - {2'b00, dvs};
  end

  assign bus.div_by_zero = dz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_sign <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      if (state != IDLE && bus.flush) begin
        // Abort: HI/LO were never touched, so they still hold the
        // pre-operation values.
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
`ifdef MULDIV_DIV_EN
              dz_q <= 1'b0;
`endif
              case (bus.op)
                OP_MTHI: begin
                  hi_q   <= bus.a;
                  done_q <= 1'b1;
                end
                OP_MTLO: begin
                  lo_q   <= bus.a;
                  done_q <= 1'b1;
                end
                OP_MULTU, OP_MULT: begin
                  mul_a    <= bus.a;
                  mul_b    <= bus.b;
                  mul_sign <= bus.op[0];
                  cnt      <= 6'(MUL_LATENCY);
                  busy_q   <= 1'b1;
                  state    <= MUL;
                end
`ifdef MULDIV_DIV_EN
                OP_DIVU, OP_DIV: begin
                  busy_q <= 1'b1;
                  if (bus.b == 32'd0) begin
                    quo   <= bus.a;
                    state <= DZ;
                  end else begin
                    quo   <= a_mag;
                    dvs   <= b_mag;
                    rem   <= '0;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    cnt   <= 6'd32;
                    state <= DIV;
                  end
                end
`endif
                default: begin
                  done_q <= 1'b1;
                  bad_q  <= 1'b1;
                end
              endcase
            end
          end
          MUL: begin
            if (cnt == 6'd1) begin
              hi_q   <= product[63:32];
              lo_q   <= product[31:0];
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
`ifdef MULDIV_DIV_EN
          DIV: begin
            if (!trial[33]) begin
              rem <= trial[32:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= {rem[31:0], quo[31]};
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state <= FIX;
            end
          end
          FIX: begin
            // For DIVU both flags are clear. 0x80000000 / -1 negates to
            // itself, which is the wanted result.
            lo_q   <= q_neg ? -quo : quo;
            hi_q   <= r_neg ? -rem[31:0] : rem[31:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          DZ: begin
            lo_q   <= 32'hFFFF_FFFF;
            hi_q   <= quo;
            dz_q   <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
`endif
          default: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ready  = !busy_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.bad_op = bad_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign dbg_state  = state;

endmodule
